// File: rtl/call_stack.sv
// Hardware return-address stack: push/pop/replace-top/flush with occupancy status and sticky error flags.
// Optional macro CALL_STACK_WRAP_EN: a push while full overwrites the oldest entry instead of being dropped.
module call_stack #(
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic              flush,
  output logic [ADDR_W-1:0] top_addr,
  output logic [CNT_W-1:0]  count,
  output logic              empty,
  output logic              full,
  output logic              overflow,
  output logic              underflow
);

  localparam int SP_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [SP_W-1:0]  SP_LAST  = SP_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [ADDR_W-1:0] mem_q [DEPTH];
  logic [SP_W-1:0]   sp_q, sp_d;
  logic [SP_W-1:0]   sp_inc, sp_dec;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              wr_en;
  logic [SP_W-1:0]   wr_idx;
  logic              is_empty, is_full;

  // The pointer wraps explicitly so DEPTH need not be a power of two.
  assign sp_inc   = (sp_q == SP_LAST) ? '0 : sp_q + 1'b1;
  assign sp_dec   = (sp_q == '0) ? SP_LAST : sp_q - 1'b1;
  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == CNT_FULL);

  always_comb begin
    sp_d    = sp_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    wr_en   = 1'b0;
    wr_idx  = sp_q;
    if (rst) begin
      sp_d    = '0;
      count_d = '0;
      ovf_d   = 1'b0;
      unf_d   = 1'b0;
    end else if (flush) begin
      sp_d    = '0;
      count_d = '0;
    end else if (push && pop && !is_empty) begin
      // Replace-top: a RET immediately followed by a CALL in the same cycle.
      wr_en  = 1'b1;
      wr_idx = sp_dec;
    end else if (push) begin
      if (!is_full) begin
        wr_en   = 1'b1;
        sp_d    = sp_inc;
        count_d = count_q + 1'b1;
      end else begin
        ovf_d = 1'b1;
`ifdef CALL_STACK_WRAP_EN
        wr_en = 1'b1;
        sp_d  = sp_inc;
`else
        wr_en = 1'b0;
`endif
      end
    end else if (pop) begin
      if (is_empty) begin
        unf_d = 1'b1;
      end else begin
        sp_d    = sp_dec;
        count_d = count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    sp_q    <= sp_d;
    count_q <= count_d;
    ovf_q   <= ovf_d;
    unf_q   <= unf_d;
  end

  // Storage is never reset; only the pointer and count define validity.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_idx] <= push_addr;
    end
  end

  assign top_addr  = is_empty ? '0 : mem_q[sp_dec];
  assign count     = count_q;
  assign empty     = is_empty;
  assign full      = is_full;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule

// File: tb/tb_call_stack.sv
// Self-checking bench for call_stack (DEPTH=4, ADDR_W=12) using a queue-based return-stack model.
module tb_call_stack;

  localparam int ADDR_W = 12;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              push = 1'b0;
  logic              pop = 1'b0;
  logic              flush = 1'b0;
  logic [ADDR_W-1:0] push_addr = '0;
  logic [ADDR_W-1:0] top_addr;
  logic [CNT_W-1:0]  count;
  logic              empty, full, overflow, underflow;

  int checks = 0;
  int errors = 0;

  logic [ADDR_W-1:0] model_q[$];
  logic              m_ovf = 1'b0;
  logic              m_unf = 1'b0;

  always #5 clk = ~clk;

  call_stack #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .push_addr(push_addr),
    .flush(flush), .top_addr(top_addr), .count(count), .empty(empty),
    .full(full), .overflow(overflow), .underflow(underflow)
  );

  // Apply one cycle of inputs, clock it, and advance the reference model.
  task automatic cycle(input logic r, input logic f, input logic pu, input logic po,
                       input logic [ADDR_W-1:0] a);
    rst = r; flush = f; push = pu; pop = po; push_addr = a;
    @(posedge clk);
    #1;
    if (r) begin
      model_q.delete(); m_ovf = 1'b0; m_unf = 1'b0;
    end else if (f) begin
      model_q.delete();
    end else if (pu && po && model_q.size() > 0) begin
      model_q[model_q.size() - 1] = a;
    end else if (pu) begin
      if (model_q.size() < DEPTH) model_q.push_back(a);
      else begin
        m_ovf = 1'b1;
`ifdef CALL_STACK_WRAP_EN
        void'(model_q.pop_front());
        model_q.push_back(a);
`endif
      end
    end else if (po) begin
      if (model_q.size() == 0) m_unf = 1'b1;
      else void'(model_q.pop_back());
    end
    rst = 1'b0; flush = 1'b0; push = 1'b0; pop = 1'b0;
  endtask

  task automatic test_reset();
    cycle(1, 0, 0, 0, '0);
    checks++; if (count !== 0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b exp 1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", full); end
    checks++; if (top_addr !== 12'h000) begin errors++; $display("FAIL reset_top got %h exp 000", top_addr); end
    checks++; if ({overflow, underflow} !== 2'b00) begin errors++; $display("FAIL reset_flags got %b%b exp 00", overflow, underflow); end
    $display("test_reset: count=%0d empty=%b top=%h", count, empty, top_addr);
  endtask

  task automatic test_push_pop();
    logic [ADDR_W-1:0] exp_top [3];
    exp_top[0] = 12'h020; exp_top[1] = 12'h010; exp_top[2] = 12'h000;
    cycle(1, 0, 0, 0, '0);
    cycle(0, 0, 1, 0, 12'h010);
    cycle(0, 0, 1, 0, 12'h020);
    cycle(0, 0, 1, 0, 12'h030);
    checks++; if (count !== 3 || top_addr !== 12'h030) begin errors++; $display("FAIL push3 got count=%0d top=%h exp 3/030", count, top_addr); end
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 0, 1, '0);
      checks++; if (top_addr !== exp_top[i]) begin errors++; $display("FAIL pop_top[%0d] got %h exp %h", i, top_addr, exp_top[i]); end
      $display("test_push_pop: pop %0d top=%h count=%0d", i, top_addr, count);
    end
    checks++; if (empty !== 1'b1 || overflow !== 1'b0 || underflow !== 1'b0) begin errors++; $display("FAIL pop_end got empty=%b ovf=%b unf=%b exp 1/0/0", empty, overflow, underflow); end
  endtask

  task automatic test_overflow();
    logic [ADDR_W-1:0] exp_pop [4];
`ifdef CALL_STACK_WRAP_EN
    logic [ADDR_W-1:0] exp_top5 = 12'h005;
    exp_pop[0] = 12'h005; exp_pop[1] = 12'h004; exp_pop[2] = 12'h003; exp_pop[3] = 12'h002;
`else
    logic [ADDR_W-1:0] exp_top5 = 12'h004;
    exp_pop[0] = 12'h004; exp_pop[1] = 12'h003; exp_pop[2] = 12'h002; exp_pop[3] = 12'h001;
`endif
    cycle(1, 0, 0, 0, '0);
    for (int i = 1; i <= 4; i++) cycle(0, 0, 1, 0, ADDR_W'(i));
    checks++; if (full !== 1'b1 || overflow !== 1'b0) begin errors++; $display("FAIL fill got full=%b ovf=%b exp 1/0", full, overflow); end
    cycle(0, 0, 1, 0, 12'h005);
    checks++; if (count !== 4 || top_addr !== exp_top5 || overflow !== 1'b1) begin errors++; $display("FAIL push_full got count=%0d top=%h ovf=%b exp 4/%h/1", count, top_addr, overflow, exp_top5); end
    $display("test_overflow: push while full top=%h count=%0d ovf=%b", top_addr, count, overflow);
    for (int i = 0; i < 4; i++) begin
      checks++; if (top_addr !== exp_pop[i]) begin errors++; $display("FAIL ovf_pop[%0d] got %h exp %h", i, top_addr, exp_pop[i]); end
      cycle(0, 0, 0, 1, '0);
    end
    checks++; if (empty !== 1'b1 || overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got empty=%b ovf=%b exp 1/1", empty, overflow); end
  endtask

  task automatic test_underflow_replace();
    cycle(1, 0, 0, 0, '0);
    cycle(0, 0, 0, 1, '0);
    checks++; if (underflow !== 1'b1 || count !== 0) begin errors++; $display("FAIL underflow got unf=%b count=%0d exp 1/0", underflow, count); end
    cycle(0, 0, 1, 1, 12'h0AA);
    checks++; if (count !== 1 || top_addr !== 12'h0AA || underflow !== 1'b1) begin errors++; $display("FAIL pushpop_empty got count=%0d top=%h unf=%b exp 1/0aa/1", count, top_addr, underflow); end
    $display("test_underflow_replace: unf=%b count=%0d top=%h", underflow, count, top_addr);
  endtask

  task automatic test_replace_top();
    cycle(1, 0, 0, 0, '0);
    cycle(0, 0, 1, 0, 12'h100);
    cycle(0, 0, 1, 0, 12'h200);
    cycle(0, 0, 1, 1, 12'h2FF);
    checks++; if (count !== 2 || top_addr !== 12'h2FF) begin errors++; $display("FAIL replace got count=%0d top=%h exp 2/2ff", count, top_addr); end
    cycle(0, 0, 0, 1, '0);
    checks++; if (top_addr !== 12'h100) begin errors++; $display("FAIL replace_pop got %h exp 100", top_addr); end
    // Replace-top while full must not set overflow.
    cycle(0, 0, 1, 0, 12'h300); cycle(0, 0, 1, 0, 12'h400); cycle(0, 0, 1, 0, 12'h500);
    cycle(0, 0, 1, 1, 12'h5AA);
    checks++; if (full !== 1'b1 || top_addr !== 12'h5AA || overflow !== 1'b0) begin errors++; $display("FAIL replace_full got full=%b top=%h ovf=%b exp 1/5aa/0", full, top_addr, overflow); end
    $display("test_replace_top: top=%h count=%0d", top_addr, count);
  endtask

  task automatic test_flush_reset();
    cycle(1, 0, 0, 0, '0);
    cycle(0, 0, 0, 1, '0);
    cycle(0, 0, 1, 0, 12'h111);
    cycle(0, 0, 1, 0, 12'h222);
    cycle(0, 1, 1, 0, 12'h333);
    checks++; if (count !== 0 || empty !== 1'b1 || top_addr !== 12'h000) begin errors++; $display("FAIL flush got count=%0d empty=%b top=%h exp 0/1/000", count, empty, top_addr); end
    checks++; if (underflow !== 1'b1 || overflow !== 1'b0) begin errors++; $display("FAIL flush_flags got ovf=%b unf=%b exp 0/1", overflow, underflow); end
    for (int i = 0; i < 3; i++) cycle(0, 0, 1, 0, ADDR_W'(12'h0A0 + i));
    cycle(1, 0, 1, 0, 12'h777);
    checks++; if (count !== 0 || empty !== 1'b1 || full !== 1'b0 || top_addr !== 12'h000 || overflow !== 1'b0 || underflow !== 1'b0) begin
      errors++; $display("FAIL mid_reset got count=%0d empty=%b full=%b top=%h ovf=%b unf=%b", count, empty, full, top_addr, overflow, underflow);
    end
    $display("test_flush_reset: count=%0d empty=%b", count, empty);
  endtask

  task automatic test_random();
    logic r, f, pu, po;
    logic [ADDR_W-1:0] a, m_top;
    cycle(1, 0, 0, 0, '0);
    for (int n = 0; n < 400; n++) begin
      r  = ($urandom_range(99) == 0);
      f  = ($urandom_range(49) == 0);
      pu = ($urandom_range(99) < 55);
      po = ($urandom_range(99) < 45);
      a  = ADDR_W'($urandom);
      cycle(r, f, pu, po, a);
      m_top = (model_q.size() > 0) ? model_q[model_q.size() - 1] : '0;
      checks++;
      if (count !== CNT_W'(model_q.size()) || top_addr !== m_top || empty !== (model_q.size() == 0) ||
          full !== (model_q.size() == DEPTH) || overflow !== m_ovf || underflow !== m_unf) begin
        errors++;
        $display("FAIL random[%0d] got cnt=%0d top=%h e=%b f=%b o=%b u=%b exp cnt=%0d top=%h o=%b u=%b",
                 n, count, top_addr, empty, full, overflow, underflow, model_q.size(), m_top, m_ovf, m_unf);
      end
      $display("test_random[%0d]: r=%b f=%b push=%b pop=%b a=%h -> cnt=%0d top=%h", n, r, f, pu, po, a, count, top_addr);
    end
  endtask

  initial begin
    test_reset();
    test_push_pop();
    test_overflow();
    test_underflow_replace();
    test_replace_top();
    test_flush_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
